// File: rtl/lis3dh_spi_responder.sv
// LIS3DH SPI-slave model: mode-3 framing, control/status/output register map,
// host-fed XYZ samples with BDU and overrun handling, and the INT1 data-ready line.
module lis3dh_spi_responder #(
   parameter logic [7:0] WHO_AM_I_VAL = 8'h33,
   parameter logic [7:0] CTRL1_RST    = 8'h07
) (
   input  logic        CLK12M,
   input  logic        RST_BTN,
   input  logic        LIS3DH_SCLK,
   input  logic        LIS3DH_SS,
   input  logic        LIS3DH_MOSI,
   output logic        LIS3DH_MISO,
   output logic        MISO_OE,
   input  logic        SAMPLE_VALID,
   input  logic [15:0] SAMPLE_X,
   input  logic [15:0] SAMPLE_Y,
   input  logic [15:0] SAMPLE_Z,
   output logic [1:0]  LIS3DH_INT
);

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      DATA
   } state_t;

   state_t state, state_next;

   logic [2:0]  sclk_sync;
   logic [2:0]  ss_sync;
   logic [1:0]  mosi_sync;
   logic        sclk_rise, sclk_fall, ss_fall, ss_high, mosi;

   logic [2:0]  bit_cnt;
   logic [7:0]  rx;
   logic [7:0]  rx_byte;
   logic [7:0]  tx;
   logic        rw, ms;
   logic [5:0]  addr, next_addr, load_addr;
   logic        byte_done, load_tx, write_en, flag_clear;
   logic        miso, miso_oe;

   logic [7:0]  ctrl [6];
   logic [15:0] out_x, out_y, out_z;
   logic        zyxda, zyxor, int1;

   assign sclk_rise   = sclk_sync[1] & ~sclk_sync[2];
   assign sclk_fall   = ~sclk_sync[1] & sclk_sync[2];
   assign ss_fall     = ~ss_sync[1] & ss_sync[2];
   assign ss_high     = ss_sync[1];
   assign mosi        = mosi_sync[1];

   assign LIS3DH_MISO = miso;
   assign MISO_OE     = miso_oe;
   assign LIS3DH_INT  = {1'b0, int1};

   // Register-map read mux shared by every TX load
   function automatic logic [7:0] reg_read(input logic [5:0] a);
      logic [7:0] v;
      v = '0;
      if (a == 6'h0F)
         v = WHO_AM_I_VAL;
      else if (a[5:3] == 3'b100 && a[2:0] <= 3'd5)
         v = ctrl[a[2:0]];
      else if (a == 6'h27)
         v = {zyxor, 3'b000, zyxda, 3'b000};
      else if (a == 6'h28)
         v = out_x[7:0];
      else if (a == 6'h29)
         v = out_x[15:8];
      else if (a == 6'h2A)
         v = out_y[7:0];
      else if (a == 6'h2B)
         v = out_y[15:8];
      else if (a == 6'h2C)
         v = out_z[7:0];
      else if (a == 6'h2D)
         v = out_z[15:8];
      return v;
   endfunction

   // Two-stage synchronisers plus one history stage for edge detection.
   // SS resets low so a frame already in progress at reset is ignored until SS
   // has been seen high and falls again.
   always_ff @(posedge CLK12M) begin
      if (RST_BTN) begin
         sclk_sync <= '1;
         ss_sync   <= '0;
         mosi_sync <= '0;
      end else begin
         sclk_sync <= {sclk_sync[1:0], LIS3DH_SCLK};
         ss_sync   <= {ss_sync[1:0], LIS3DH_SS};
         mosi_sync <= {mosi_sync[0], LIS3DH_MOSI};
      end
   end

   // FSM state register
   always_ff @(posedge CLK12M) begin
      if (RST_BTN)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next state and byte-boundary controls; SS high always wins over a byte end
   always_comb begin
      state_next = state;
      rx_byte    = {rx[6:0], mosi};
      next_addr  = ms ? addr + 6'd1 : addr;
      byte_done  = 1'b0;
      load_tx    = 1'b0;
      load_addr  = addr;
      write_en   = 1'b0;
      case (state)
         IDLE: begin
            if (ss_fall)
               state_next = CMD;
         end
         CMD: begin
            if (ss_high) begin
               state_next = IDLE;
            end else if (sclk_rise && bit_cnt == 3'd7) begin
               byte_done  = 1'b1;
               state_next = DATA;
               load_tx    = rx_byte[7];
               load_addr  = rx_byte[5:0];
            end
         end
         DATA: begin
            if (ss_high) begin
               state_next = IDLE;
            end else if (sclk_rise && bit_cnt == 3'd7) begin
               byte_done = 1'b1;
               load_tx   = rw;
               load_addr = next_addr;
               write_en  = ~rw && addr[5:3] == 3'b100 && addr[2:0] <= 3'd5;
            end
         end
         default: state_next = IDLE;
      endcase
      flag_clear = load_tx && load_addr == 6'h2D;
   end

   // Shift/count datapath and MISO driver
   always_ff @(posedge CLK12M) begin
      if (RST_BTN) begin
         bit_cnt <= '0;
         rx      <= '0;
         tx      <= '0;
         rw      <= 1'b0;
         ms      <= 1'b0;
         addr    <= '0;
         miso    <= 1'b0;
         miso_oe <= 1'b0;
      end else begin
         if (state == IDLE)
            bit_cnt <= '0;
         else if (sclk_rise)
            bit_cnt <= bit_cnt + 3'd1;

         if (state != IDLE && sclk_rise)
            rx <= rx_byte;

         if (state == CMD && byte_done) begin
            rw   <= rx_byte[7];
            ms   <= rx_byte[6];
            addr <= rx_byte[5:0];
         end else if (state == DATA && byte_done) begin
            addr <= next_addr;
         end

         if (load_tx) begin
            tx <= reg_read(load_addr);
         end else if (state == DATA && rw && sclk_fall && !ss_high) begin
            miso    <= tx[7];
            tx      <= {tx[6:0], 1'b0};
            miso_oe <= 1'b1;
         end else if (state == IDLE) begin
            miso    <= 1'b0;
            miso_oe <= 1'b0;
         end
      end
   end

   // Control registers, sample latch with BDU/overrun, and registered INT1
   always_ff @(posedge CLK12M) begin
      if (RST_BTN) begin
         ctrl[0] <= CTRL1_RST;
         for (int unsigned i = 1; i < 6; i++)
            ctrl[i] <= '0;
         out_x <= '0;
         out_y <= '0;
         out_z <= '0;
         zyxda <= 1'b0;
         zyxor <= 1'b0;
         int1  <= 1'b0;
      end else begin
         if (write_en)
            ctrl[addr[2:0]] <= rx_byte;

         // A sample coinciding with the OUT_Z_H load overrides the flag clear
         if (SAMPLE_VALID) begin
            if (flag_clear || !(ctrl[3][7] && zyxda)) begin
               out_x <= SAMPLE_X;
               out_y <= SAMPLE_Y;
               out_z <= SAMPLE_Z;
            end
            zyxda <= 1'b1;
            zyxor <= flag_clear ? 1'b0 : (zyxor | zyxda);
         end else if (flag_clear) begin
            zyxda <= 1'b0;
            zyxor <= 1'b0;
         end

         int1 <= zyxda & ctrl[2][4];
      end
   end

endmodule

// File: tb/tb_lis3dh_spi_responder.sv
// Self-checking bench for lis3dh_spi_responder: directed register/sample scenarios
// followed by randomized frames checked against a register-level model.
module tb_lis3dh_spi_responder;

   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        rst, sclk, ss, mosi, miso, miso_oe, sample_valid;
   logic [15:0] sx, sy, sz;
   logic [1:0]  int_o;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] tx_buf  [16];
   logic [7:0] rx_buf  [16];
   logic [7:0] exp_buf [16];
   int         oe_err;
   logic       int_after_cmd;

   // register-level model of the sensor
   logic [7:0]  m_ctrl [6];
   logic [15:0] m_x, m_y, m_z;
   logic        m_da, m_or;

   always #5 clk = ~clk;

   lis3dh_spi_responder #(
      .WHO_AM_I_VAL(8'h33),
      .CTRL1_RST   (8'h07)
   ) dut (
      .CLK12M      (clk),
      .RST_BTN     (rst),
      .LIS3DH_SCLK (sclk),
      .LIS3DH_SS   (ss),
      .LIS3DH_MOSI (mosi),
      .LIS3DH_MISO (miso),
      .MISO_OE     (miso_oe),
      .SAMPLE_VALID(sample_valid),
      .SAMPLE_X    (sx),
      .SAMPLE_Y    (sy),
      .SAMPLE_Z    (sz),
      .LIS3DH_INT  (int_o)
   );

   function automatic logic [7:0] m_read(input logic [5:0] a);
      if (a == 6'h0F) return 8'h33;
      if (a >= 6'h20 && a <= 6'h25) return m_ctrl[a - 6'h20];
      if (a == 6'h27) return (m_or ? 8'h80 : 8'h00) | (m_da ? 8'h08 : 8'h00);
      case (a)
         6'h28: return m_x[7:0];
         6'h29: return m_x[15:8];
         6'h2A: return m_y[7:0];
         6'h2B: return m_y[15:8];
         6'h2C: return m_z[7:0];
         6'h2D: return m_z[15:8];
         default: return 8'h00;
      endcase
   endfunction

   task automatic m_reset();
      m_ctrl[0] = 8'h07;
      for (int i = 1; i < 6; i++) m_ctrl[i] = 8'h00;
      m_x = 0; m_y = 0; m_z = 0;
      m_da = 0; m_or = 0;
   endtask

   task automatic m_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
      if (m_ctrl[3][7] && m_da) begin
         m_or = 1;
      end else begin
         m_x = x; m_y = y; m_z = z;
         if (m_da) m_or = 1;
         m_da = 1;
      end
   endtask

   // every register loaded for transmit, including the one after the last byte
   task automatic model_read(input logic [5:0] a, input logic ms_f, input int n);
      logic [5:0] p;
      p = a;
      for (int i = 0; i <= n; i++) begin
         if (i < n) exp_buf[i] = m_read(p);
         if (p == 6'h2D) begin m_da = 0; m_or = 0; end
         if (ms_f) p = p + 6'd1;
      end
   endtask

   task automatic model_write(input logic [5:0] a, input logic ms_f, input int n);
      logic [5:0] p;
      p = a;
      for (int i = 0; i < n; i++) begin
         if (p >= 6'h20 && p <= 6'h25) m_ctrl[p - 6'h20] = tx_buf[i + 1];
         if (ms_f) p = p + 6'd1;
      end
   endtask

   // mode-3 master: nbytes full bytes from tx_buf, then part_bits of the next byte
   task automatic spi_frame(input int nbytes, input int part_bits);
      logic is_read;
      int   total;
      int   nbits;
      is_read = tx_buf[0][7];
      total   = nbytes + ((part_bits > 0) ? 1 : 0);
      oe_err  = 0;
      @(negedge clk);
      ss = 1'b0;
      repeat (6) @(negedge clk);
      for (int b = 0; b < total; b++) begin
         nbits = (b == nbytes) ? part_bits : 8;
         for (int i = 7; i > 7 - nbits; i--) begin
            sclk = 1'b0;
            mosi = tx_buf[b][i];
            repeat (HALF) @(negedge clk);
            rx_buf[b][i] = miso;
            if (miso_oe !== (is_read && b > 0)) oe_err++;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
         end
         if (b == 0) int_after_cmd = int_o[0];
      end
      repeat (4) @(negedge clk);
      ss = 1'b1;
      repeat (6) @(negedge clk);
      if (miso_oe !== 1'b0) oe_err++;
   endtask

   task automatic do_read(input logic [5:0] a, input logic ms_f, input int n);
      tx_buf[0] = {1'b1, ms_f, a};
      for (int i = 1; i <= n; i++) tx_buf[i] = 8'h00;
      model_read(a, ms_f, n);
      spi_frame(n + 1, 0);
   endtask

   task automatic do_write(input logic [5:0] a, input logic ms_f, input int n);
      tx_buf[0] = {1'b0, ms_f, a};
      model_write(a, ms_f, n);
      spi_frame(n + 1, 0);
   endtask

   task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
      @(negedge clk);
      sample_valid = 1'b1;
      sx = x; sy = y; sz = z;
      @(negedge clk);
      sample_valid = 1'b0;
      m_sample(x, y, z);
      repeat (2) @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      m_reset();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      vectors++;
      if (miso !== 1'b0) begin
         miscompares++; $display("FAIL reset_miso: got %b expected 0", miso);
      end
      vectors++;
      if (miso_oe !== 1'b0) begin
         miscompares++; $display("FAIL reset_oe: got %b expected 0", miso_oe);
      end
      vectors++;
      if (int_o !== 2'b00) begin
         miscompares++; $display("FAIL reset_int: got %b expected 00", int_o);
      end
      do_read(6'h20, 1'b0, 1);
      vectors++;
      if (rx_buf[1] !== 8'h07) begin
         miscompares++; $display("FAIL reset_ctrl1: got %h expected 07", rx_buf[1]);
      end
   endtask

   task automatic test_who_am_i();
      do_read(6'h0F, 1'b0, 1);
      vectors++;
      if (rx_buf[1] !== 8'h33) begin
         miscompares++; $display("FAIL who_am_i: got %h expected 33", rx_buf[1]);
      end
      vectors++;
      if (oe_err !== 0) begin
         miscompares++; $display("FAIL who_am_i_oe: got %0d bad OE samples expected 0", oe_err);
      end
   endtask

   task automatic test_write_read();
      tx_buf[1] = 8'h57;
      do_write(6'h20, 1'b0, 1);
      vectors++;
      if (oe_err !== 0) begin
         miscompares++; $display("FAIL write_oe: got %0d bad OE samples expected 0", oe_err);
      end
      do_read(6'h20, 1'b0, 1);
      vectors++;
      if (rx_buf[1] !== 8'h57) begin
         miscompares++; $display("FAIL ctrl1_readback: got %h expected 57", rx_buf[1]);
      end
      do_read(6'h21, 1'b0, 1);
      vectors++;
      if (rx_buf[1] !== 8'h00) begin
         miscompares++; $display("FAIL ctrl2_readback: got %h expected 00", rx_buf[1]);
      end
   endtask

   task automatic test_burst();
      logic [47:0] lit;
      lit = 48'h3412DCFE0180;
      pulse_sample(16'h1234, 16'hFEDC, 16'h8001);
      do_read(6'h28, 1'b1, 6);
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (rx_buf[i + 1] !== lit[47 - 8*i -: 8]) begin
            miscompares++;
            $display("FAIL burst_byte%0d: got %h expected %h", i, rx_buf[i + 1], lit[47 - 8*i -: 8]);
         end
      end
      do_read(6'h27, 1'b0, 1);
      vectors++;
      if (rx_buf[1] !== 8'h00) begin
         miscompares++; $display("FAIL burst_status_cleared: got %h expected 00", rx_buf[1]);
      end
   endtask

   task automatic test_overrun_int();
      tx_buf[1] = 8'h10;
      do_write(6'h22, 1'b0, 1);
      pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
      pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
      vectors++;
      if (int_o !== 2'b01) begin
         miscompares++; $display("FAIL int_set: got %b expected 01", int_o);
      end
      do_read(6'h27, 1'b0, 1);
      vectors++;
      if (rx_buf[1] !== 8'h88) begin
         miscompares++; $display("FAIL overrun_status: got %h expected 88", rx_buf[1]);
      end
      do_read(6'h2D, 1'b0, 1);
      vectors++;
      if (int_after_cmd !== 1'b0) begin
         miscompares++; $display("FAIL int_clear_on_2d: got %b expected 0", int_after_cmd);
      end
      vectors++;
      if (rx_buf[1] !== m_z[15:8]) begin
         miscompares++; $display("FAIL out_z_h: got %h expected %h", rx_buf[1], m_z[15:8]);
      end
   endtask

   task automatic test_bdu();
      tx_buf[1] = 8'h80;
      do_write(6'h23, 1'b0, 1);
      do_read(6'h2D, 1'b0, 1);
      pulse_sample(16'h0001, 16'($urandom), 16'($urandom));
      pulse_sample(16'h0002, 16'($urandom), 16'($urandom));
      do_read(6'h28, 1'b0, 1);
      vectors++;
      if (rx_buf[1] !== 8'h01) begin
         miscompares++; $display("FAIL bdu_hold: got %h expected 01", rx_buf[1]);
      end
      do_read(6'h27, 1'b0, 1);
      vectors++;
      if (rx_buf[1] !== 8'h88) begin
         miscompares++; $display("FAIL bdu_status: got %h expected 88", rx_buf[1]);
      end
   endtask

   task automatic test_abort_wrap();
      tx_buf[0] = 8'h21;
      tx_buf[1] = 8'hAB;
      spi_frame(1, 4);
      do_read(6'h21, 1'b0, 1);
      vectors++;
      if (rx_buf[1] !== 8'h00) begin
         miscompares++; $display("FAIL abort_no_write: got %h expected 00", rx_buf[1]);
      end
      do_read(6'h3F, 1'b1, 2);
      vectors++;
      if (tx_buf[0] !== 8'hFF || rx_buf[1] !== 8'h00 || rx_buf[2] !== 8'h00) begin
         miscompares++;
         $display("FAIL wrap_read: got %h %h expected 00 00", rx_buf[1], rx_buf[2]);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] pat;
      int          bad;
      bad = 0;
      pat = 16'h20FF;
      @(negedge clk);
      ss = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         sclk = 1'b0; mosi = 1'b1;
         repeat (HALF) @(negedge clk);
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      apply_reset();
      vectors++;
      if (int_o !== 2'b00) begin
         miscompares++; $display("FAIL midframe_reset_int: got %b expected 00", int_o);
      end
      for (int i = 15; i >= 0; i--) begin
         sclk = 1'b0; mosi = pat[i];
         repeat (HALF) @(negedge clk);
         if (miso_oe !== 1'b0) bad++;
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      ss = 1'b1;
      repeat (6) @(negedge clk);
      vectors++;
      if (bad !== 0) begin
         miscompares++; $display("FAIL midframe_oe: got %0d bad OE samples expected 0", bad);
      end
      do_read(6'h20, 1'b0, 1);
      vectors++;
      if (rx_buf[1] !== 8'h07) begin
         miscompares++; $display("FAIL midframe_ignored: got %h expected 07", rx_buf[1]);
      end
   endtask

   task automatic test_random();
      int          op, n;
      logic        ms_f;
      logic [5:0]  a;
      for (int it = 0; it < 40; it++) begin
         op   = $urandom_range(0, 2);
         n    = $urandom_range(1, 3);
         ms_f = 1'($urandom);
         if (op == 0) begin
            pulse_sample(16'($urandom), 16'($urandom), 16'($urandom));
         end else if (op == 1) begin
            a = ($urandom_range(0, 9) < 7) ? 6'(6'h20 + $urandom_range(0, 5)) : 6'($urandom);
            for (int i = 1; i <= n; i++) tx_buf[i] = 8'($urandom);
            do_write(a, ms_f, n);
         end else begin
            a = ($urandom_range(0, 1) == 1) ? 6'(6'h27 + $urandom_range(0, 6)) : 6'($urandom);
            do_read(a, ms_f, n + 1);
            for (int i = 0; i <= n; i++) begin
               vectors++;
               if (rx_buf[i + 1] !== exp_buf[i]) begin
                  miscompares++;
                  $display("FAIL rand_read addr %h ms %b byte %0d: got %h expected %h",
                           a, ms_f, i, rx_buf[i + 1], exp_buf[i]);
               end
            end
            vectors++;
            if (oe_err !== 0) begin
               miscompares++; $display("FAIL rand_read_oe: got %0d bad OE samples expected 0", oe_err);
            end
         end
         repeat (3) @(negedge clk);
         vectors++;
         if (int_o !== {1'b0, m_da & m_ctrl[2][4]}) begin
            miscompares++;
            $display("FAIL rand_int: got %b expected %b", int_o, {1'b0, m_da & m_ctrl[2][4]});
         end
      end
   endtask

   initial begin
      rst = 1'b1; sclk = 1'b1; ss = 1'b1; mosi = 1'b0;
      sample_valid = 1'b0; sx = '0; sy = '0; sz = '0;
      test_reset();
      test_who_am_i();
      test_write_read();
      test_burst();
      test_overrun_int();
      test_bdu();
      test_abort_wrap();
      test_reset_mid_frame();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lis3dh_spi_responder.md
# lis3dh_spi_responder

SPI-slave model of the LIS3DH accelerometer for the MAX1000 Nios lab. It terminates the Nios SPI master pins on the LIS3DH side. It answers register reads and writes with LIS3DH framing and serves host-supplied X/Y/Z samples through OUT_X_L..OUT_Z_H. It also raises the data-ready interrupt. It replaces the physical sensor in simulation and in loop-back builds, so firmware can be exercised with known acceleration data.

## Interface
Parameters:
- WHO_AM_I_VAL, 8'h33, value returned at address 0x0F.
- CTRL1_RST, 8'h07, reset value of CTRL_REG1 (0x20).

Ports (name, direction, width, meaning):
- CLK12M, in, 1, system clock; the only clock.
- RST_BTN, in, 1, reset; synchronous, active-high.
- LIS3DH_SCLK, in, 1, SPI clock from the master, mode 3 (idle high), asynchronous to CLK12M.
- LIS3DH_SS, in, 1, chip select, active-low.
- LIS3DH_MOSI, in, 1, master data out.
- LIS3DH_MISO, out, 1, slave data out.
- MISO_OE, out, 1, 1 while SS is low and a read data phase is active; the pad tristates when 0.
- SAMPLE_VALID, in, 1, one-cycle strobe; latch a new sample.
- SAMPLE_X, in, 16, X axis, two's complement.
- SAMPLE_Y, in, 16, Y axis, two's complement.
- SAMPLE_Z, in, 16, Z axis, two's complement.
- LIS3DH_INT, out, 2, [0]=INT1 data-ready, [1]=INT2 (always 0).

## Operation
- Input synchronisation: SCLK, SS and MOSI each pass through a 2-FF synchroniser. Rising and falling SCLK edges are detected from the synchronised value.
- Framing: all bit counting is on rising SCLK edges while SS is low.
  - Byte 0 is the command, MSB first: bit7 = RW (1 = read), bit6 = MS (1 = auto-increment), bits5:0 = ADDR.
  - Every following byte is a data byte.
- State machine:
  - IDLE -> CMD when SS falls; bit counter cleared.
  - CMD -> DATA on the 8th rising edge; ADDR and flags latched. If RW=1, the register at ADDR is loaded into the TX shift register.
  - DATA, write: each 8th rising edge commits the RX byte to ADDR.
  - DATA, read: each 8th rising edge loads the next register into the TX shift register.
  - After each data byte, ADDR increments by 1 if MS=1, wrapping 0x3F to 0x00. If MS=0, ADDR is unchanged.
  - Any state -> IDLE when SS rises. A partial byte is discarded: no write, no flag clear.
- MISO: on each falling SCLK edge in a read DATA phase, MISO <= tx[7] and tx shifts left. MISO_OE = 1 from the first falling edge after the command byte until SS rises.
- Register map:
  - 0x0F: WHO_AM_I_VAL, read-only.
  - 0x20..0x25: CTRL_REG1..6, read/write. Reset value CTRL1_RST for 0x20, 0x00 for the others.
  - 0x27: STATUS_REG, read-only. bit3 = ZYXDA, bit7 = ZYXOR, other bits 0.
  - 0x28..0x2D: OUT_X_L, OUT_X_H, OUT_Y_L, OUT_Y_H, OUT_Z_L, OUT_Z_H, read-only.
  - All other addresses read 0x00; writes to them are ignored.
  - Writes to read-only addresses are ignored.
- Sample latch:
  - On SAMPLE_VALID, the OUT registers take X, Y and Z, and ZYXDA is set.
  - If ZYXDA was already 1, ZYXOR is also set.
  - Block data update: if CTRL_REG4[7] (BDU) = 1 and ZYXDA = 1, the OUT registers hold their values. Only ZYXOR sets.
- Flag clear: loading 0x2D into the TX shift register clears ZYXDA and ZYXOR.
  - If SAMPLE_VALID arrives in the same cycle, the sample wins: ZYXDA = 1, ZYXOR = 0, OUT registers updated.
- Interrupt: LIS3DH_INT[0] = ZYXDA & CTRL_REG3[4] (I1_ZYXDA), registered. LIS3DH_INT[1] = 0.

## Timing
- Reset values:
  - Outputs: LIS3DH_MISO=0, MISO_OE=0, LIS3DH_INT=2'b00.
  - Registers: CTRL_REG1=CTRL1_RST, CTRL_REG2..6=0, OUT registers=0, ZYXDA=0, ZYXOR=0.
  - State machine: IDLE.
- Reset during a frame: the block returns to IDLE immediately. It ignores SCLK until SS has been seen high and then falls again.
- Edge-detect latency: 3 CLK12M cycles from a pad edge to the internal strobe.
- SCLK limits: SCLK half-period must be at least 6 CLK12M cycles (SCLK ≤ 1 MHz). SS setup to the first SCLK falling edge must be at least 4 cycles.
- MISO validity: MISO is updated 4 cycles after the pad falling edge. It is stable before the next rising edge at 1 MHz.
- Register writes take effect 1 cycle after the 8th-edge strobe.
- INT1 follows ZYXDA with 1 cycle latency.
- Simultaneous SS rise and 8th rising edge in the same cycle: SS wins and the byte is discarded.

## Test plan
- Read WHO_AM_I: frame 0x8F, 0x00 -> MISO returns 0x33; MISO_OE high only during byte 1.
- Write then read: write 0x20, data 0x57; then read 0xA0 -> returns 0x57. Read 0x21 -> 0x00.
- Burst read with auto-increment: SAMPLE X=0x1234, Y=0xFEDC, Z=0x8001; read 0xE8 for 6 bytes -> 34 12 DC FE 01 80; ZYXDA=0 after the 6th byte is loaded.
- Overrun and interrupt:
  - Set CTRL_REG3=0x10, then pulse SAMPLE_VALID twice with no read -> STATUS=0x88, INT[0]=1.
  - Read 0x2D -> INT[0]=0 within 2 cycles.
- BDU hold: CTRL_REG4=0x80; first sample X=0x0001, second X=0x0002 before reading -> OUT_X_L reads 0x01.
- Abort and address wrap:
  - SS rises after 4 bits of a write byte to 0x21 -> CTRL_REG2 stays 0x00.
  - Burst read 0xFF for 2 bytes -> 0x00, then 0x00 from wrapped address 0x00.
